// File: rtl/btn_event_ctrl_if.sv
// Event channel between btn_event_ctrl and its consumer.
// The master side holds the event; the slave side accepts it with i_Evt_Ready.
interface btn_event_ctrl_if;
  logic       o_Evt_Valid;
  logic [1:0] o_Evt_Code;
  logic       i_Evt_Ready;

  modport master (output o_Evt_Valid, output o_Evt_Code, input i_Evt_Ready);
  modport slave  (input o_Evt_Valid, input o_Evt_Code, output i_Evt_Ready);
endinterface

// File: rtl/btn_event_ctrl.sv
// Button event sequencer: turns a debounced level into PRESS/RELEASE/LONG(/REPEAT) events.
// Optional auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
//
// state       | meaning
// S_IDLE      | button released, waiting for a rising edge
// S_HELD      | pressed, counting towards the long-press threshold
// S_REPEAT    | long press seen, emitting REPEAT every REPEAT_CYCLES (auto-repeat build)
// S_LONG_HOLD | long press seen, waiting only for release (default build)
module btn_event_ctrl #(
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Debounced,
  input  logic                 i_Clr_Overflow,
  output logic                 o_Overflow,
  output logic [1:0]           o_State,
  btn_event_ctrl_if.master     evt
);

  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;

  // Parameter sanity checks resolved at elaboration time.
  if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > LONG_PRESS_CYCLES) begin : g_bad_rep
    $error("REPEAT_CYCLES must be in 2..LONG_PRESS_CYCLES");
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC    = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [1:0]       EV_REPEAT = 2'd3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_REPEAT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LONG_HOLD = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             r_Prev;
  logic             rise, fall;
  logic             gen;
  logic [1:0]       gen_code;

  assign rise    = i_Debounced & ~r_Prev;
  assign fall    = ~i_Debounced & r_Prev;
  assign o_State = state;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state  <= S_IDLE;
      cnt    <= '0;
      r_Prev <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      r_Prev <= i_Debounced;
    end
  end

  // Release always wins over a terminal count seen in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gen       = 1'b0;
    gen_code  = EV_PRESS;
    case (state)
      S_IDLE: begin
        if (rise) begin
          gen       = 1'b1;
          gen_code  = EV_PRESS;
          state_nxt = S_HELD;
          cnt_nxt   = '0;
        end
      end
      S_HELD: begin
        if (fall) begin
          gen       = 1'b1;
          gen_code  = EV_RELEASE;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_TC) begin
          gen       = 1'b1;
          gen_code  = EV_LONG;
`ifdef BTN_AUTO_REPEAT_EN
          state_nxt = S_REPEAT;
`else
          state_nxt = S_LONG_HOLD;
`endif
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      S_REPEAT: begin
        if (fall) begin
          gen       = 1'b1;
          gen_code  = EV_RELEASE;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REP_TC) begin
          gen      = 1'b1;
          gen_code = EV_REPEAT;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`else
      S_LONG_HOLD: begin
        if (fall) begin
          gen       = 1'b1;
          gen_code  = EV_RELEASE;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Single-entry holding register; a new event arriving while the slot is stalled is dropped.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      evt.o_Evt_Valid <= 1'b0;
      evt.o_Evt_Code  <= 2'd0;
      o_Overflow      <= 1'b0;
    end else begin
      if (gen && (!evt.o_Evt_Valid || evt.i_Evt_Ready)) begin
        evt.o_Evt_Valid <= 1'b1;
        evt.o_Evt_Code  <= gen_code;
      end else if (evt.o_Evt_Valid && evt.i_Evt_Ready) begin
        evt.o_Evt_Valid <= 1'b0;
      end
      if (gen && evt.o_Evt_Valid && !evt.i_Evt_Ready) begin
        o_Overflow <= 1'b1;
      end else if (i_Clr_Overflow) begin
        o_Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4.
// Expectations follow BTN_AUTO_REPEAT_EN when the bench is built with that macro.
module tb_btn_event_ctrl;
  localparam logic [1:0] PRESS = 2'd0, REL = 2'd1, LONG = 2'd2, REP = 2'd3;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, deb, clr;
  logic ovf;
  logic [1:0] st;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int t;
  exp_t exp_q[$];

  btn_event_ctrl_if bus ();

  btn_event_ctrl #(.LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Debounced    (deb),
    .i_Clr_Overflow (clr),
    .o_Overflow     (ovf),
    .o_State        (st),
    .evt            (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: an event transfers at the next rising edge when valid & ready.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus.o_Evt_Valid && bus.i_Evt_Ready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", bus.o_Evt_Code, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.o_Evt_Code !== e.code || (e.cyc >= 0 && cyc != e.cyc)) begin
          nerr++;
          $display("FAIL event: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                   bus.o_Evt_Code, cyc, e.code, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    deb   = 1'b0;
    clr   = 1'b0;
    bus.i_Evt_Ready = 1'b1;
    step(2);
    chk("rst_valid", int'(bus.o_Evt_Valid), 0);
    chk("rst_code", int'(bus.o_Evt_Code), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_state", int'(st), 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_valid", int'(bus.o_Evt_Valid), 0);

    // Short press: held 3 cycles.
    t = cyc + 1;
    deb = 1'b1;
    push(PRESS, t);
    step(3);
    chk("short_state_held", int'(st), 1);
    deb = 1'b0;
    push(REL, t + 3);
    step(4);
    chk("short_state_idle", int'(st), 0);

    // Long hold: held 21 cycles.
    t = cyc + 1;
    deb = 1'b1;
    push(PRESS, t);
    push(LONG, t + 8);
`ifdef BTN_AUTO_REPEAT_EN
    push(REP, t + 12);
    push(REP, t + 16);
    push(REP, t + 20);
`endif
    step(11);
    chk("long_state_after", int'(st), 2);
    step(10);
    chk("long_state_still", int'(st), 2);
    deb = 1'b0;
    push(REL, t + 21);
    step(4);
    chk("long_state_idle", int'(st), 0);

    // Fall coincident with the long-press terminal count.
    t = cyc + 1;
    deb = 1'b1;
    push(PRESS, t);
    step(8);
    deb = 1'b0;
    push(REL, t + 8);
    step(4);
    chk("coinc_state", int'(st), 0);

    // Backpressure: RELEASE dropped, overflow set even while clear is asserted.
    t = cyc + 1;
    bus.i_Evt_Ready = 1'b0;
    deb = 1'b1;
    push(PRESS, -1);
    step(1);
    chk("bp_valid", int'(bus.o_Evt_Valid), 1);
    chk("bp_code", int'(bus.o_Evt_Code), 0);
    step(2);
    deb = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("bp_ovf_set_wins", int'(ovf), 1);
    chk("bp_code_kept", int'(bus.o_Evt_Code), 0);
    chk("bp_state_idle", int'(st), 0);
    step(2);
    chk("bp_ovf_sticky", int'(ovf), 1);
    chk("bp_valid_kept", int'(bus.o_Evt_Valid), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("bp_ovf_cleared", int'(ovf), 0);
    bus.i_Evt_Ready = 1'b1;
    step(2);
    chk("bp_drained", int'(bus.o_Evt_Valid), 0);

    // Async reset after the long press, then reset release with button held.
    t = cyc + 1;
    deb = 1'b1;
    push(PRESS, t);
    step(2);
    bus.i_Evt_Ready = 1'b0;
    step(12);
    chk("ar_state", int'(st), 2);
    chk("ar_valid", int'(bus.o_Evt_Valid), 1);
    chk("ar_code", int'(bus.o_Evt_Code), 2);
`ifdef BTN_AUTO_REPEAT_EN
    chk("ar_ovf", int'(ovf), 1);
`else
    chk("ar_ovf", int'(ovf), 0);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_rst_valid", int'(bus.o_Evt_Valid), 0);
    chk("ar_rst_code", int'(bus.o_Evt_Code), 0);
    chk("ar_rst_ovf", int'(ovf), 0);
    chk("ar_rst_state", int'(st), 0);
    step(1);
    rst_n = 1'b1;
    bus.i_Evt_Ready = 1'b1;
    t = cyc + 1;
    push(PRESS, t);
    step(2);
    chk("ar_state_held", int'(st), 1);
    deb = 1'b0;
    push(REL, t + 2);
    step(4);
    chk("ar_state_idle", int'(st), 0);

    step(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
